// File: rtl/jb_dfe_sched_pkg.sv
// jb_dfe_sched_pkg: carrier sequencer state encoding and shared timer width
package jb_dfe_sched_pkg;

    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } car_state_e;

endpackage

// File: rtl/jb_dfe_car_sched_if.sv
// jb_dfe_car_sched_if: control requests and per-carrier status of the carrier scheduler
interface jb_dfe_car_sched_if #(
    parameter int N_CARRIERS = 2
);

    logic [N_CARRIERS-1:0]   car_en;
    logic                    frm_mrkr;
    logic                    err_clr;
    logic [N_CARRIERS-1:0]   car_resetn;
    logic [N_CARRIERS-1:0]   clk_x1en;
    logic [N_CARRIERS-1:0]   clk_x4en;
    logic [N_CARRIERS-1:0]   clk_x8en;
    logic [N_CARRIERS-1:0]   clk_x16en;
    logic [3*N_CARRIERS-1:0] car_state;
    logic [N_CARRIERS-1:0]   align_err;

    modport master (
        output car_en, frm_mrkr, err_clr,
        input  car_resetn, clk_x1en, clk_x4en, clk_x8en, clk_x16en, car_state, align_err
    );

    modport slave (
        input  car_en, frm_mrkr, err_clr,
        output car_resetn, clk_x1en, clk_x4en, clk_x8en, clk_x16en, car_state, align_err
    );

endinterface

// File: rtl/jb_dfe_car_seq_fsm.sv
// jb_dfe_car_seq_fsm: one carrier's align/hold/run/drain sequencer with a shared down-counter
module jb_dfe_car_seq_fsm
    import jb_dfe_sched_pkg::*;
#(
    parameter int RST_HOLD = 32,
    parameter int DRAIN    = 64,
    parameter int ALIGN_TO = 65535
) (
    input  logic       clk_4x,
    input  logic       resetn_4x,
    input  logic       en,
    input  logic       grant,
    input  logic       frm_mrkr,
    input  logic       err_clr,
    output car_state_e state,
    output logic       car_resetn,
    output logic       align_err
);

    localparam logic [TMR_W-1:0] ALIGN_LD = TMR_W'(ALIGN_TO - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'(DRAIN - 1);

    car_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             car_resetn_q, car_resetn_d;
    logic             align_err_q, align_err_d;
    logic             err_set;

    // next state, timer reload on entry / decrement, sticky alignment error
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: if (grant) begin
                state_d = ST_ALIGN;
                tmr_d   = ALIGN_LD;
            end
            ST_ALIGN: if (!en) state_d = ST_IDLE;
            else if (frm_mrkr) begin
                state_d = ST_HOLD;
                tmr_d   = HOLD_LD;
            end else if (tmr_q == '0) begin
                state_d = ST_IDLE;
                err_set = 1'b1;
            end else tmr_d = tmr_q - TMR_W'(1);
            ST_HOLD: if (!en) begin
                state_d = ST_DRAIN;
                tmr_d   = DRAIN_LD;
            end else if (tmr_q == '0) state_d = ST_RUN;
            else tmr_d = tmr_q - TMR_W'(1);
            ST_RUN: if (!en) begin
                state_d = ST_DRAIN;
                tmr_d   = DRAIN_LD;
            end
            ST_DRAIN: if (tmr_q == '0) state_d = ST_IDLE;
            else tmr_d = tmr_q - TMR_W'(1);
            default: state_d = ST_IDLE;
        endcase
        car_resetn_d = state_d inside {ST_RUN, ST_DRAIN};
        align_err_d  = err_set | (align_err_q & ~err_clr);
    end

    // state, timer and registered outputs
    always_ff @(posedge clk_4x or negedge resetn_4x) begin
        if (!resetn_4x) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            car_resetn_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            car_resetn_q <= car_resetn_d;
            align_err_q  <= align_err_d;
        end
    end

    assign state      = state_q;
    assign car_resetn = car_resetn_q;
    assign align_err  = align_err_q;

endmodule

// File: rtl/jb_dfe_car_sched.sv
// jb_dfe_car_sched: phase counter, strobe decode and round-robin start arbitration for N carriers
module jb_dfe_car_sched
    import jb_dfe_sched_pkg::*;
#(
    parameter int N_CARRIERS = 2,
    parameter int PERIOD     = 64,
    parameter int RST_HOLD   = 32,
    parameter int DRAIN      = 64,
    parameter int ALIGN_TO   = 65535
) (
    input logic                clk_4x,
    input logic                resetn_4x,
    jb_dfe_car_sched_if.slave  bus
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam int RR_W  = (N_CARRIERS > 1) ? $clog2(N_CARRIERS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DIV16   = CNT_W'(PERIOD / 16);
    localparam logic [CNT_W-1:0] DIV8    = CNT_W'(PERIOD / 8);
    localparam logic [CNT_W-1:0] DIV4    = CNT_W'(PERIOD / 4);
    localparam logic [RR_W-1:0]  RR_LAST = RR_W'(N_CARRIERS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RR_W-1:0]       rr_q, rr_d, gidx;
    logic [N_CARRIERS-1:0] x1_q, x1_d, x4_q, x4_d, x8_q, x8_d, x16_q, x16_d;
    logic [N_CARRIERS-1:0] active, starting, req, grant, car_resetn, align_err;
    logic                  found, busy;
    car_state_e            st [N_CARRIERS];

    for (genvar c = 0; c < N_CARRIERS; c++) begin : g_car
        jb_dfe_car_seq_fsm #(
            .RST_HOLD (RST_HOLD),
            .DRAIN    (DRAIN),
            .ALIGN_TO (ALIGN_TO)
        ) u_fsm (
            .clk_4x     (clk_4x),
            .resetn_4x  (resetn_4x),
            .en         (bus.car_en[c]),
            .grant      (grant[c]),
            .frm_mrkr   (bus.frm_mrkr),
            .err_clr    (bus.err_clr),
            .state      (st[c]),
            .car_resetn (car_resetn[c]),
            .align_err  (align_err[c])
        );
        assign active[c]              = st[c] inside {ST_HOLD, ST_RUN, ST_DRAIN};
        assign starting[c]            = st[c] inside {ST_ALIGN, ST_HOLD};
        assign req[c]                 = (st[c] == ST_IDLE) && bus.car_en[c];
        assign bus.car_state[3*c +: 3] = st[c];
    end

    assign busy = |starting;

    // lowest requester at or after rr_ptr wins, else lowest overall; only one start in flight
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = N_CARRIERS - 1; i >= 0; i--) if (req[i]) begin
            found = 1'b1;
            gidx  = RR_W'(i);
        end
        for (int i = N_CARRIERS - 1; i >= 0; i--) if (req[i] && RR_W'(i) >= rr_q) gidx = RR_W'(i);
        grant = (found && !busy) ? N_CARRIERS'(1) << gidx : '0;
        rr_d  = (found && !busy) ? ((gidx == RR_LAST) ? '0 : gidx + RR_W'(1)) : rr_q;
    end

    // free-running phase and strobe decode gated by each carrier's current activity
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        x1_d  = (cnt_q == '0) ? active : '0;
        x4_d  = ((cnt_q % DIV4) == '0) ? active : '0;
        x8_d  = ((cnt_q % DIV8) == '0) ? active : '0;
        x16_d = ((cnt_q % DIV16) == '0) ? active : '0;
    end

    // phase counter, round-robin pointer and strobe registers
    always_ff @(posedge clk_4x or negedge resetn_4x) begin
        if (!resetn_4x) begin
            cnt_q <= '0;
            rr_q  <= '0;
            x1_q  <= '0;
            x4_q  <= '0;
            x8_q  <= '0;
            x16_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
            x1_q  <= x1_d;
            x4_q  <= x4_d;
            x8_q  <= x8_d;
            x16_q <= x16_d;
        end
    end

    assign bus.clk_x1en   = x1_q;
    assign bus.clk_x4en   = x4_q;
    assign bus.clk_x8en   = x8_q;
    assign bus.clk_x16en  = x16_q;
    assign bus.car_resetn = car_resetn;
    assign bus.align_err  = align_err;

endmodule

// File: tb/tb_jb_dfe_car_sched.sv
// tb_jb_dfe_car_sched: directed checks of sequencing, arbitration, strobes, timeouts and reset
module tb_jb_dfe_car_sched;

    logic clk_4x    = 1'b0;
    logic resetn_4x = 1'b0;
    int   cyc       = 0;
    int   vectors   = 0;
    int   miscompares = 0;

    jb_dfe_car_sched_if #(.N_CARRIERS(2)) a ();
    jb_dfe_car_sched_if #(.N_CARRIERS(2)) b ();

    jb_dfe_car_sched #(
        .N_CARRIERS(2), .PERIOD(64), .RST_HOLD(32), .DRAIN(64), .ALIGN_TO(65535)
    ) dut (
        .clk_4x    (clk_4x),
        .resetn_4x (resetn_4x),
        .bus       (a)
    );

    jb_dfe_car_sched #(
        .N_CARRIERS(2), .PERIOD(64), .RST_HOLD(32), .DRAIN(64), .ALIGN_TO(10)
    ) dut_t (
        .clk_4x    (clk_4x),
        .resetn_4x (resetn_4x),
        .bus       (b)
    );

    always #5 clk_4x = ~clk_4x;

    // rising edges seen since the last reset release
    always @(posedge clk_4x or negedge resetn_4x) cyc <= resetn_4x ? cyc + 1 : 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_4x);
            #1;
        end
    endtask

    // expected {x1,x4,x8,x16} after rising edge k for PERIOD=64
    function automatic logic [3:0] strb_exp(input int k, input logic act);
        int p;
        p = (k - 1) % 64;
        return act ? {p == 0, p % 16 == 0, p % 8 == 0, p % 4 == 0} : 4'b0000;
    endfunction

    function automatic logic [3:0] strb_c0();
        return {a.clk_x1en[0], a.clk_x4en[0], a.clk_x8en[0], a.clk_x16en[0]};
    endfunction

    task automatic test_reset();
        resetn_4x  = 1'b0;
        a.car_en   = '0;
        a.frm_mrkr = 1'b0;
        a.err_clr  = 1'b0;
        b.car_en   = '0;
        b.frm_mrkr = 1'b0;
        b.err_clr  = 1'b0;
        step(3);
        vectors++; if (a.car_state !== 6'o00) begin miscompares++; $display("FAIL reset_state got %o want 00", a.car_state); end
        vectors++; if (a.car_resetn !== 2'b00) begin miscompares++; $display("FAIL reset_car_resetn got %b want 00", a.car_resetn); end
        vectors++; if ({a.clk_x1en, a.clk_x4en, a.clk_x8en, a.clk_x16en} !== 8'h00) begin miscompares++; $display("FAIL reset_strobes got %h want 00", {a.clk_x1en, a.clk_x4en, a.clk_x8en, a.clk_x16en}); end
        vectors++; if (a.align_err !== 2'b00) begin miscompares++; $display("FAIL reset_align_err got %b want 00", a.align_err); end
        vectors++; if (b.car_state !== 6'o00) begin miscompares++; $display("FAIL reset_state_t got %o want 00", b.car_state); end
        resetn_4x = 1'b1;
    endtask

    task automatic test_round_robin();
        a.car_en = 2'b11;
        step();
        vectors++; if (a.car_state !== 6'o01) begin miscompares++; $display("FAIL rr_first_grant got %o want 01", a.car_state); end
        step(5);
        vectors++; if (a.car_state !== 6'o01) begin miscompares++; $display("FAIL rr_c1_waits got %o want 01", a.car_state); end
        a.frm_mrkr = 1'b1; step(); a.frm_mrkr = 1'b0;
        vectors++; if (a.car_state !== 6'o02) begin miscompares++; $display("FAIL rr_c0_hold got %o want 02", a.car_state); end
        step(31);
        vectors++; if (a.car_state !== 6'o02) begin miscompares++; $display("FAIL rr_c1_waits_hold got %o want 02", a.car_state); end
        step();
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o03, 2'b01}) begin miscompares++; $display("FAIL rr_c0_run got %o/%b want 03/01", a.car_state, a.car_resetn); end
        step();
        vectors++; if (a.car_state !== 6'o13) begin miscompares++; $display("FAIL rr_c1_align got %o want 13", a.car_state); end
        a.frm_mrkr = 1'b1; step(); a.frm_mrkr = 1'b0;
        vectors++; if (a.car_state !== 6'o23) begin miscompares++; $display("FAIL rr_c1_hold got %o want 23", a.car_state); end
        step(32);
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o33, 2'b11}) begin miscompares++; $display("FAIL rr_both_run got %o/%b want 33/11", a.car_state, a.car_resetn); end
        a.car_en = 2'b00;
        step();
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o44, 2'b11}) begin miscompares++; $display("FAIL rr_both_drain got %o/%b want 44/11", a.car_state, a.car_resetn); end
        step(64);
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o00, 2'b00}) begin miscompares++; $display("FAIL rr_both_idle got %o/%b want 00/00", a.car_state, a.car_resetn); end
        a.car_en = 2'b11;
        step();
        vectors++; if (a.car_state !== 6'o01) begin miscompares++; $display("FAIL rr_ptr_wrapped got %o want 01", a.car_state); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp;
        a.car_en = 2'b10;
        step();
        vectors++; if ({a.car_state, a.align_err} !== {6'o00, 2'b00}) begin miscompares++; $display("FAIL align_abort got %o/%b want 00/00", a.car_state, a.align_err); end
        step();
        vectors++; if (a.car_state !== 6'o10) begin miscompares++; $display("FAIL c1_granted got %o want 10", a.car_state); end
        a.frm_mrkr = 1'b1; step(); a.frm_mrkr = 1'b0;
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o20, 2'b00}) begin miscompares++; $display("FAIL c1_hold got %o/%b want 20/00", a.car_state, a.car_resetn); end
        a.car_en = 2'b00;
        step();
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o40, 2'b10}) begin miscompares++; $display("FAIL hold_abort_drain got %o/%b want 40/10", a.car_state, a.car_resetn); end
        step(5);
        #3 resetn_4x = 1'b0;
        #1;
        vectors++; if ({a.car_state, a.car_resetn, a.align_err} !== 10'd0) begin miscompares++; $display("FAIL async_reset_state got %o/%b/%b want 00/00/00", a.car_state, a.car_resetn, a.align_err); end
        vectors++; if ({a.clk_x1en, a.clk_x4en, a.clk_x8en, a.clk_x16en} !== 8'h00) begin miscompares++; $display("FAIL async_reset_strobes got %h want 00", {a.clk_x1en, a.clk_x4en, a.clk_x8en, a.clk_x16en}); end
        a.car_en   = 2'b01;
        a.frm_mrkr = 1'b1;
        #2 resetn_4x = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            step();
            if (k == 2) a.frm_mrkr = 1'b0;
            exp = {3'd0, (k == 1) ? 3'd1 : (k < 34) ? 3'd2 : 3'd3, k >= 34, strb_exp(k, k >= 3)};
            vectors++;
            if ({a.car_state, a.car_resetn[0], strb_c0()} !== exp) begin
                miscompares++;
                $display("FAIL restart_k%0d got %b want %b", k, {a.car_state, a.car_resetn[0], strb_c0()}, exp);
            end
        end
    endtask

    task automatic test_align_hold();
        logic [10:0] exp;
        resetn_4x  = 1'b0;
        a.car_en   = 2'b01;
        a.frm_mrkr = 1'b0;
        step(2);
        resetn_4x = 1'b1;
        while (cyc < 100) step();
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o01, 2'b00}) begin miscompares++; $display("FAIL align_wait_c100 got %o/%b want 01/00", a.car_state, a.car_resetn); end
        a.frm_mrkr = 1'b1; step(); a.frm_mrkr = 1'b0;
        for (int k = 101; k <= 200; k++) begin
            exp = {3'd0, (k < 133) ? 3'd2 : 3'd3, k >= 133, strb_exp(k, k >= 102)};
            vectors++;
            if ({a.car_state, a.car_resetn[0], strb_c0()} !== exp) begin
                miscompares++;
                $display("FAIL hold_run_k%0d got %b want %b", k, {a.car_state, a.car_resetn[0], strb_c0()}, exp);
            end
            step();
        end
    endtask

    task automatic test_drain();
        int n16 = 0, n1 = 0, n_after = 0;
        logic [2:0] late;
        a.car_en = 2'b00;
        step();
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o04, 2'b01}) begin miscompares++; $display("FAIL drain_entry got %o/%b want 04/01", a.car_state, a.car_resetn); end
        for (int i = 1; i <= 64; i++) begin
            step();
            n16 += int'(a.clk_x16en[0]);
            n1  += int'(a.clk_x1en[0]);
            if (i == 63) late = a.car_state[2:0];
        end
        vectors++; if (late !== 3'd4) begin miscompares++; $display("FAIL drain_last_cycle got %0d want 4", late); end
        vectors++; if ({a.car_state, a.car_resetn} !== {6'o00, 2'b00}) begin miscompares++; $display("FAIL drain_done got %o/%b want 00/00", a.car_state, a.car_resetn); end
        vectors++; if (n16 !== 16) begin miscompares++; $display("FAIL drain_x16_pulses got %0d want 16", n16); end
        vectors++; if (n1 !== 1) begin miscompares++; $display("FAIL drain_x1_pulses got %0d want 1", n1); end
        for (int i = 0; i < 64; i++) begin
            step();
            n_after += int'(|{a.clk_x1en, a.clk_x4en, a.clk_x8en, a.clk_x16en});
        end
        vectors++; if (n_after !== 0) begin miscompares++; $display("FAIL strobes_after_drain got %0d want 0", n_after); end
    endtask

    task automatic test_align_timeout();
        b.car_en = 2'b01;
        step();
        vectors++; if ({b.car_state, b.car_resetn} !== {6'o01, 2'b00}) begin miscompares++; $display("FAIL to_align got %o/%b want 01/00", b.car_state, b.car_resetn); end
        step(9);
        vectors++; if ({b.car_state, b.align_err} !== {6'o01, 2'b00}) begin miscompares++; $display("FAIL to_last_wait got %o/%b want 01/00", b.car_state, b.align_err); end
        step();
        vectors++; if ({b.car_state, b.align_err} !== {6'o00, 2'b01}) begin miscompares++; $display("FAIL to_expired got %o/%b want 00/01", b.car_state, b.align_err); end
        b.car_en = 2'b00;
        step();
        vectors++; if ({b.car_state, b.align_err} !== {6'o00, 2'b01}) begin miscompares++; $display("FAIL to_sticky got %o/%b want 00/01", b.car_state, b.align_err); end
        b.err_clr = 1'b1; step(); b.err_clr = 1'b0;
        vectors++; if (b.align_err !== 2'b00) begin miscompares++; $display("FAIL to_err_clr got %b want 00", b.align_err); end
        b.car_en = 2'b01;
        step(10);
        b.frm_mrkr = 1'b1; step(); b.frm_mrkr = 1'b0;
        vectors++; if ({b.car_state, b.align_err} !== {6'o02, 2'b00}) begin miscompares++; $display("FAIL to_marker_at_expiry got %o/%b want 02/00", b.car_state, b.align_err); end
        b.car_en = 2'b00;
        step(65);
        vectors++; if (b.car_state !== 6'o00) begin miscompares++; $display("FAIL to_drained got %o want 00", b.car_state); end
        b.car_en = 2'b01;
        step(10);
        b.err_clr = 1'b1; step(); b.err_clr = 1'b0;
        b.car_en = 2'b00;
        vectors++; if ({b.car_state, b.align_err} !== {6'o00, 2'b01}) begin miscompares++; $display("FAIL to_set_beats_clr got %o/%b want 00/01", b.car_state, b.align_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_reset_mid();
        test_align_hold();
        test_drain();
        test_align_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
